// File: rtl/write_back_register_file_if.sv
// Write-back/read bundle between the CPU datapath and the architectural register file.
interface write_back_register_file_if #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] WriteAddr;
    logic                  WriteEnable;
    logic [ADDR_WIDTH-1:0] ReadAddr1;
    logic [ADDR_WIDTH-1:0] ReadAddr2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] LinkValue;
    logic                  ClearStart;
    logic                  Busy;

    modport master (
        output WriteData, WriteAddr, WriteEnable, ReadAddr1, ReadAddr2, ClearStart,
        input  ReadData1, ReadData2, LinkValue, Busy
    );

    modport slave (
        input  WriteData, WriteAddr, WriteEnable, ReadAddr1, ReadAddr2, ClearStart,
        output ReadData1, ReadData2, LinkValue, Busy
    );
endinterface

// File: rtl/write_back_register_file.sv
// Sixteen-entry architectural register file with r0 hardwired to zero, a same-cycle
// write-to-read bypass and a sequential clear sweep controlled by a two-state machine.
module write_back_register_file #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 4,
    parameter int LINK_REG   = 10
) (
    input  logic                     Clock,
    input  logic                     Reset,
    write_back_register_file_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] counter;
    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  wr_ok;

    // Writes (and therefore the bypass) are only honoured outside the sweep.
    assign wr_ok = bus.WriteEnable && !busy && (bus.WriteAddr != '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                regs[bus.WriteAddr] <= bus.WriteData;
            end
            case (state)
                IDLE: begin
                    if (bus.ClearStart) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        counter <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                CLEAR: begin
                    regs[counter] <= '0;
                    if (counter == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ReadData1 = regs[bus.ReadAddr1];
        if (bus.ReadAddr1 == '0) begin
            bus.ReadData1 = '0;
        end else if (wr_ok && (bus.ReadAddr1 == bus.WriteAddr)) begin
            bus.ReadData1 = bus.WriteData;
        end
    end

    always_comb begin
        bus.ReadData2 = regs[bus.ReadAddr2];
        if (bus.ReadAddr2 == '0) begin
            bus.ReadData2 = '0;
        end else if (wr_ok && (bus.ReadAddr2 == bus.WriteAddr)) begin
            bus.ReadData2 = bus.WriteData;
        end
    end

    assign bus.LinkValue = regs[LINK_REG];
    assign bus.Busy      = busy;
endmodule

// File: tb/tb_write_back_register_file.sv
// Directed self-checking bench for write_back_register_file.
module tb_write_back_register_file;
    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    write_back_register_file_if #(.DATA_WIDTH(17), .ADDR_WIDTH(4)) bus ();

    write_back_register_file #(.DATA_WIDTH(17), .ADDR_WIDTH(4), .LINK_REG(10)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [16:0] d);
        bus.WriteAddr   = a;
        bus.WriteData   = d;
        bus.WriteEnable = 1'b1;
        tick();
        bus.WriteEnable = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.WriteData = '0; bus.WriteAddr = '0; bus.WriteEnable = 1'b0;
        bus.ReadAddr1 = '0; bus.ReadAddr2 = '0; bus.ClearStart = 1'b0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            bus.ReadAddr1 = 4'(i);
            bus.ReadAddr2 = 4'(15 - i);
            #1;
            check("reset_rd1", bus.ReadData1, 17'h0);
            check("reset_rd2", bus.ReadData2, 17'h0);
        end
        check("reset_busy", {16'b0, bus.Busy}, 17'h0);
        check("reset_link", bus.LinkValue, 17'h0);

        // Bypass then array read
        bus.ReadAddr1 = 4'd5; bus.WriteAddr = 4'd5; bus.WriteData = 17'h1ABCD; bus.WriteEnable = 1'b1;
        #1;
        check("bypass_r5", bus.ReadData1, 17'h1ABCD);
        tick();
        bus.WriteEnable = 1'b0;
        #1;
        check("array_r5", bus.ReadData1, 17'h1ABCD);

        // Link register, no bypass
        bus.WriteAddr = 4'd10; bus.WriteData = 17'h0000A; bus.WriteEnable = 1'b1;
        #1;
        check("link_no_bypass", bus.LinkValue, 17'h0);
        tick();
        bus.WriteEnable = 1'b0;
        #1;
        check("link_after", bus.LinkValue, 17'h0000A);

        // r0 hardwired zero
        bus.ReadAddr2 = 4'd0; bus.WriteAddr = 4'd0; bus.WriteData = 17'h1FFFF; bus.WriteEnable = 1'b1;
        #1;
        check("r0_bypass", bus.ReadData2, 17'h0);
        tick();
        bus.WriteEnable = 1'b0;
        #1;
        check("r0_after", bus.ReadData2, 17'h0);

        // Fill r1..r15 with their index, then sweep
        for (int i = 1; i < 16; i++) write_reg(4'(i), 17'(i));
        bus.ReadAddr1 = 4'd7; bus.ReadAddr2 = 4'd15;
        #1;
        check("fill_r7", bus.ReadData1, 17'd7);
        check("fill_r15", bus.ReadData2, 17'd15);
        bus.ClearStart = 1'b1;
        #1;
        check("busy_before_edge", {16'b0, bus.Busy}, 17'h0);
        tick();
        bus.ClearStart = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.Busy) break;
            cnt++;
            if (k == 0) begin
                bus.ReadAddr1 = 4'd3; bus.WriteAddr = 4'd3; bus.WriteData = 17'h1FFFF; bus.WriteEnable = 1'b1;
                #1;
                check("sweep_no_bypass", bus.ReadData1, 17'd3);
            end else if (k == 1) begin
                bus.WriteEnable = 1'b0;
                bus.ReadAddr2 = 4'd1;
                #1;
                check("sweep_write_dropped", bus.ReadData1, 17'd3);
                check("sweep_r1_cleared", bus.ReadData2, 17'h0);
            end
            tick();
        end
        check("busy_cycles", 17'(cnt), 17'd15);
        for (int i = 0; i < 16; i++) begin
            bus.ReadAddr1 = 4'(i);
            #1;
            check("after_sweep", bus.ReadData1, 17'h0);
        end
        check("after_sweep_link", bus.LinkValue, 17'h0);

        // Reset in the middle of a sweep
        write_reg(4'd10, 17'h00005);
        write_reg(4'd12, 17'h0000C);
        write_reg(4'd4, 17'h00777);
        bus.ClearStart = 1'b1;
        tick();
        bus.ClearStart = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("mid_sweep_busy", {16'b0, bus.Busy}, 17'h1);
        bus.ReadAddr1 = 4'd12;
        #1;
        check("mid_sweep_r12", bus.ReadData1, 17'h0000C);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check("rst_busy", {16'b0, bus.Busy}, 17'h0);
        check("rst_r12", bus.ReadData1, 17'h0);
        check("rst_link", bus.LinkValue, 17'h0);
        bus.ReadAddr1 = 4'd4;
        #1;
        check("rst_r4", bus.ReadData1, 17'h0);
        write_reg(4'd4, 17'h00123);
        #1;
        check("post_rst_write", bus.ReadData1, 17'h00123);
        check("post_rst_busy", {16'b0, bus.Busy}, 17'h0);

        // ClearStart and write on the same edge
        bus.ReadAddr1 = 4'd2; bus.WriteAddr = 4'd2; bus.WriteData = 17'h00055;
        bus.WriteEnable = 1'b1; bus.ClearStart = 1'b1;
        #1;
        check("cs_bypass", bus.ReadData1, 17'h00055);
        tick();
        bus.WriteEnable = 1'b0; bus.ClearStart = 1'b0;
        #1;
        check("cs_committed", bus.ReadData1, 17'h00055);
        check("cs_busy", {16'b0, bus.Busy}, 17'h1);
        tick();
        check("cs_sweep1", bus.ReadData1, 17'h00055);
        tick();
        check("cs_sweep2", bus.ReadData1, 17'h0);
        cnt = 0;
        while (bus.Busy && cnt < 20) begin
            tick();
            cnt++;
        end
        check("cs_sweep_done", {16'b0, bus.Busy}, 17'h0);
        bus.ReadAddr1 = 4'd4;
        #1;
        check("cs_r4_cleared", bus.ReadData1, 17'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
